// File: rtl/div_hhb_pkg.sv
// Shared constants, width helpers and FSM states for the truncated-operand HHB divider.
package div_hhb_pkg;

    // Default number of LSBs dropped from B (and twice that from Z)
    localparam int TRUNC_DEF = 6;

    // Reduced dividend width
    function automatic int dw_of(input int t);
        return 32 - 2 * t;
    endfunction

    // Reduced divisor width
    function automatic int vw_of(input int t);
        return 16 - t;
    endfunction

    // One restoring step per dividend bit
    function automatic int n_of(input int t);
        return dw_of(t);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational radix-2 restoring division step.
module div_restore_step #(
    parameter int VW = 10
) (
    input  logic [VW-1:0] rem,
    input  logic          din,
    input  logic [VW-1:0] div,
    output logic [VW-1:0] rem_nxt,
    output logic          qbit
);

    logic [VW:0] trial;

    // Shift in the next dividend bit; subtract when the divisor fits.
    // rem < div holds on entry, so trial < 2*div and the difference fits in VW bits.
    always_comb begin
        trial   = {rem, din};
        qbit    = (trial >= {1'b0, div});
        rem_nxt = qbit ? VW'(trial - {1'b0, div}) : trial[VW-1:0];
    end

endmodule

// File: rtl/div32u_hhb_seq.sv
// Sequential approximate unsigned divider: recovers the reduced factor of an HHB product.
module div32u_hhb_seq
    import div_hhb_pkg::*;
#(
    parameter int TRUNC = TRUNC_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             Z,
    input  logic [15:0]             B,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             Q,
    output logic [vw_of(TRUNC)-1:0] R,
    output logic                    OVF,
    output logic                    DZ
);

    localparam int DW = dw_of(TRUNC);
    localparam int VW = vw_of(TRUNC);
    localparam int N  = n_of(TRUNC);
    localparam int CW = 6;

    state_t          state, state_n;
    logic [DW-1:0]   zd;
    logic [VW-1:0]   bd;
    logic [VW-1:0]   rem;
    logic [DW-1:0]   q;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic [VW-1:0]   b_red;
    logic [VW-1:0]   rem_nxt;
    logic            qbit;
    logic [DW-1:0]   q_fin;
    logic            ovf_fin;
    logic [15:0]     q_fmt;
    logic            unused_bits;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign b_red     = B[15 -: VW];

    // Dropped LSBs, and the quotient MSB that shifts out on the final step
    assign unused_bits = ^{Z, B, q[DW-1]};

    div_restore_step #(.VW(VW)) u_step (
        .rem     (rem),
        .din     (zd[DW-1]),
        .div     (bd),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // Final quotient including this cycle's bit, and its saturated 16-bit form
    always_comb begin
        q_fin   = {q[DW-2:0], qbit};
        ovf_fin = |q_fin[DW-1:VW];
        q_fmt   = ovf_fin ? 16'hFFFF : (16'(q_fin[VW-1:0]) << TRUNC);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = (b_red == '0) ? DONE : CALC;
            CALC: if (cnt == '0) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            zd  <= '0;
            bd  <= '0;
            rem <= '0;
            q   <= '0;
            cnt <= '0;
            Q   <= '0;
            R   <= '0;
            OVF <= 1'b0;
            DZ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        zd  <= Z[31 -: DW];
                        bd  <= b_red;
                        rem <= '0;
                        q   <= '0;
                        cnt <= CW'(N - 1);
                        if (b_red == '0) begin
                            Q   <= 16'hFFFF;
                            R   <= '0;
                            OVF <= 1'b0;
                            DZ  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    q   <= q_fin;
                    zd  <= {zd[DW-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        Q   <= q_fmt;
                        R   <= rem_nxt;
                        OVF <= ovf_fin;
                        DZ  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32u_hhb_seq.sv
// Directed and randomized checks for the HHB approximate divider.
module tb_div32u_hhb_seq;

    localparam int T  = 6;
    localparam int VW = 16 - T;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   Z = '0;
    logic [15:0]   B = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   Q;
    logic [VW-1:0] R;
    logic          OVF;
    logic          DZ;

    int n_chk  = 0;
    int n_fail = 0;

    div32u_hhb_seq #(.TRUNC(T)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Z         (Z),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .OVF       (OVF),
        .DZ        (DZ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] z;
        logic [15:0] b;
        logic [15:0] q;
        logic [9:0]  r;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: integer divide of the reduced operands
    function automatic void model(input logic [31:0] z, input logic [15:0] b,
                                  output logic [15:0] q, output logic [9:0] r,
                                  output logic ovf, output logic dz);
        int unsigned zd, bd, qq;
        zd = z >> (2 * T);
        bd = b >> T;
        if (bd == 0) begin
            q = 16'hFFFF; r = '0; ovf = 1'b0; dz = 1'b1;
        end else begin
            qq  = zd / bd;
            r   = 10'(zd % bd);
            dz  = 1'b0;
            ovf = (qq >= (1 << VW));
            q   = ovf ? 16'hFFFF : 16'(qq << T);
        end
    endfunction

    // Present an operand pair for one accepting edge; scramble inputs afterwards
    task automatic start_op(input logic [31:0] z, input logic [15:0] b);
        @(negedge CLK);
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        Z = z; B = b; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        Z = 32'hDEAD_BEEF; B = 16'h0000;
    endtask

    // Edges from acceptance (inclusive) until out_valid is seen
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!out_valid) begin
            n_chk++; n_fail++;
            $display("FAIL wait_done: out_valid not seen within %0d cycles", lat);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        chk("consume_out_valid", {31'b0, out_valid}, 32'd0);
        chk("consume_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] q, input logic [9:0] r,
                                input logic ovf, input logic dz);
        chk({tag, "_Q"}, {16'b0, Q}, {16'b0, q});
        chk({tag, "_R"}, {22'b0, R}, {22'b0, r});
        chk({tag, "_OVF"}, {31'b0, OVF}, {31'b0, ovf});
        chk({tag, "_DZ"}, {31'b0, DZ}, {31'b0, dz});
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        logic [15:0] eq;
        logic [9:0]  er;
        logic        eo, ed;

        vecs[0]  = '{32'h0040_0000, 16'h0400, 16'h1000, 10'd0,    1'b0, 1'b0, 21};
        vecs[1]  = '{32'h1234_5678, 16'h003F, 16'hFFFF, 10'd0,    1'b0, 1'b1, 1};
        vecs[2]  = '{32'hFFFF_FFFF, 16'h0040, 16'hFFFF, 10'd0,    1'b1, 1'b0, 21};
        vecs[3]  = '{32'h0000_1000, 16'h0080, 16'h0000, 10'd1,    1'b0, 1'b0, 21};
        vecs[4]  = '{32'h0001_3000, 16'h0140, 16'h00C0, 10'd4,    1'b0, 1'b0, 21};
        vecs[5]  = '{32'hFFFF_F000, 16'hFFC0, 16'hFFFF, 10'd0,    1'b1, 1'b0, 21};
        vecs[6]  = '{32'hFF80_1000, 16'hFFC0, 16'hFFC0, 10'd0,    1'b0, 1'b0, 21};
        vecs[7]  = '{32'h003F_F000, 16'h0040, 16'hFFC0, 10'd0,    1'b0, 1'b0, 21};
        vecs[8]  = '{32'h0040_0000, 16'h0040, 16'hFFFF, 10'd0,    1'b1, 1'b0, 21};
        vecs[9]  = '{32'h0000_0000, 16'h1234, 16'h0000, 10'd0,    1'b0, 1'b0, 21};
        vecs[10] = '{32'h0006_4000, 16'h01C0, 16'h0380, 10'd2,    1'b0, 1'b0, 21};
        vecs[11] = '{32'h0006_4FFF, 16'h01FF, 16'h0380, 10'd2,    1'b0, 1'b0, 21};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check_result("reset", 16'h0, 10'd0, 1'b0, 1'b0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // A stray out_ready while idle must do nothing
        out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        out_ready = 1'b0;
        chk("idle_out_ready_ignored", {30'b0, out_valid, in_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].z, vecs[i].b);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].ovf, vecs[i].dz);
            consume();
        end

        // Backpressure: result and handshake held while out_ready is low
        start_op(32'h0001_3000, 16'h0140);
        wait_done(lat);
        in_valid = 1'b1; Z = 32'h0040_0000; B = 16'h0400;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            chk($sformatf("bp%0d_out_valid", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
            check_result($sformatf("bp%0d", c), 16'h00C0, 10'd4, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        consume();

        // Reset during CALC aborts the operation
        start_op(32'h0040_0000, 16'h0400);
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk("midop_busy", {30'b0, in_ready, out_valid}, 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_result("midop_reset", 16'h0, 10'd0, 1'b0, 1'b0);
        chk("midop_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midop_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        start_op(32'h0040_0000, 16'h0400);
        wait_done(lat);
        chk("after_reset_latency", lat, 21);
        check_result("after_reset", 16'h1000, 10'd0, 1'b0, 1'b0);
        consume();

        // Reset while holding a result in DONE
        start_op(32'h0000_1000, 16'h0080);
        wait_done(lat);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_result("done_reset", 16'h0, 10'd0, 1'b0, 1'b0);
        chk("done_reset_hs", {30'b0, in_ready, out_valid}, 32'd2);
        @(negedge CLK);
        RST = 1'b0;

        // Random HHB products: exact factor recovery against the reference
        for (int k = 0; k < 1500; k++) begin
            logic [15:0] a, b;
            logic [31:0] z;
            a = 16'($urandom);
            b = 16'($urandom);
            z = (32'(a >> T) * 32'(b >> T)) << (2 * T);
            model(z, b, eq, er, eo, ed);
            start_op(z, b);
            wait_done(lat);
            chk($sformatf("rnd%0d a=%h b=%h", k, a, b), {Q, 6'b0, R}, {eq, 6'b0, er});
            chk($sformatf("rnd%0d_flags", k), {30'b0, OVF, DZ}, {30'b0, eo, ed});
            if (ed == 1'b0)
                chk($sformatf("rnd%0d_exact", k), {16'b0, Q}, {16'b0, a[15:T], 6'b0});
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
